// File: rtl/alu_pkg.sv
// Shared opcode encoding, sequencer state encoding and opcode legality helper
// for the 8-bit ALU and its command-side sequencer.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_LAST = 4'b1001;

  localparam logic [1:0] SEQ_IDLE  = 2'd0;
  localparam logic [1:0] SEQ_ISSUE = 2'd1;
  localparam logic [1:0] SEQ_RESP  = 2'd2;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op > OP_LAST;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command-side driver for the combinational ALU: latches one operation, holds it
// on alu_* for a settle window, captures the result and returns it with an accumulator.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1   // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  input  logic             acc_clr,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_err,
  output logic [WIDTH-1:0] acc
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             accept;
  logic             err;

  // Gated with rst so the channel reads not-ready for the whole reset pulse.
  assign cmd_ready  = (state == SEQ_IDLE) && !rst;
  assign rsp_valid  = (state == SEQ_RESP);
  assign accept     = cmd_valid && cmd_ready;
  assign err        = is_illegal_op(op_q) || ((op_q == OP_DIV) && (b_q == '0));

  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

  // NOTE: every register here is reset; state lives only in flops, so a reset
  // mid-operation leaves nothing stale behind and rsp_valid drops immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SEQ_IDLE;
      cnt          <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc          <= '0;
      rsp_y        <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of acc/cnt/state regardless of statement order.
      case (state)
        SEQ_IDLE: begin
          if (acc_clr) acc <= '0;
          if (accept) begin
            op_q  <= cmd_opcode;
            b_q   <= cmd_b;
            // A same-edge clear wins over the old accumulator value.
            a_q   <= cmd_use_acc ? (acc_clr ? '0 : acc) : cmd_a;
            cnt   <= SETTLE_INIT;
            state <= SEQ_ISSUE;
          end
        end
        SEQ_ISSUE: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (err) begin
              rsp_y        <= '0;
              rsp_zero     <= 1'b1;
              rsp_overflow <= 1'b0;
              rsp_err      <= 1'b1;
            end else begin
              rsp_y        <= alu_y;
              rsp_zero     <= alu_zero;
              rsp_overflow <= alu_overflow;
              rsp_err      <= 1'b0;
              acc          <= alu_y;
            end
            state <= SEQ_RESP;
          end
        end
        SEQ_RESP: begin
          if (rsp_ready) state <= SEQ_IDLE;
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule
